// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline defaults and fetch state encoding
package pipeline_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC  = 64'h0;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DROP = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [63:0] next_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - stage register {addr, instr, valid} with load/hold/flush
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int          AW        = 64,
  parameter int          IW        = 32,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          hold,
  input  logic          flush,
  input  logic [AW-1:0] d_addr,
  input  logic [IW-1:0] d_instr,
  input  logic          d_valid,
  output logic [AW-1:0] q_addr,
  output logic [IW-1:0] q_instr,
  output logic          q_valid
);

  // Flush beats hold beats load; with none asserted the contents stay put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_addr  <= '0;
      q_instr <= IW'(NOP_INSTR);
      q_valid <= 1'b0;
    end else if (flush) begin
      q_addr  <= '0;
      q_instr <= IW'(NOP_INSTR);
      q_valid <= 1'b0;
    end else if (!hold && load) begin
      q_addr  <= d_addr;
      q_instr <= d_instr;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with IF/ID register
module instr_fetch
  import pipeline_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] Inst_Addr_Out,
  output logic [31:0] Instruction_Out,
  output logic        Valid_Out
);

  fetch_state_e state, state_n;
  logic [63:0]  pc, pc_n;
  logic [63:0]  redirect_pc, redirect_pc_n;
  logic [63:0]  hold_addr, hold_addr_n;
  logic [31:0]  hold_instr, hold_instr_n;
  logic         hold_full, hold_full_n;

  logic         ifid_load, ifid_hold, ifid_flush;
  logic [63:0]  ifid_addr;
  logic [31:0]  ifid_instr;
  logic         ifid_valid;
  logic         resp;

  assign imem_req  = reset && (state != ST_HOLD);
  assign imem_addr = pc;
  assign resp      = imem_req && imem_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      hold_addr   <= '0;
      hold_instr  <= NOP_INSTR;
      hold_full   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      redirect_pc <= redirect_pc_n;
      hold_addr   <= hold_addr_n;
      hold_instr  <= hold_instr_n;
      hold_full   <= hold_full_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    redirect_pc_n = redirect_pc;
    hold_addr_n   = hold_addr;
    hold_instr_n  = hold_instr;
    hold_full_n   = hold_full;
    ifid_load     = 1'b0;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_addr     = pc;
    ifid_instr    = imem_rdata;
    ifid_valid    = 1'b1;

    if (branch_taken) begin
      ifid_flush  = 1'b1;
      hold_full_n = 1'b0;
      // An unanswered request must keep its address, so park the target.
      if (state != ST_HOLD && !resp) begin
        redirect_pc_n = branch_target;
        state_n       = ST_DROP;
      end else begin
        pc_n    = branch_target;
        state_n = ST_REQ;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (resp) begin
            pc_n = next_pc(pc);
            if (stall) begin
              ifid_hold    = 1'b1;
              hold_addr_n  = pc;
              hold_instr_n = imem_rdata;
              hold_full_n  = 1'b1;
              state_n      = ST_HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (stall) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_load  = 1'b1;
            ifid_addr  = Inst_Addr_Out;
            ifid_instr = Instruction_Out;
            ifid_valid = 1'b0;
          end
        end
        ST_DROP: begin
          ifid_hold = 1'b1;
          if (resp) begin
            pc_n    = redirect_pc;
            state_n = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (stall) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_load   = 1'b1;
            ifid_addr   = hold_addr;
            ifid_instr  = hold_instr;
            ifid_valid  = hold_full;
            hold_full_n = 1'b0;
            state_n     = ST_REQ;
          end
        end
        default: state_n = ST_REQ;
      endcase
    end
  end

  if_id_reg #(
    .AW        (64),
    .IW        (32),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (ifid_load),
    .hold    (ifid_hold),
    .flush   (ifid_flush),
    .d_addr  (ifid_addr),
    .d_instr (ifid_instr),
    .d_valid (ifid_valid),
    .q_addr  (Inst_Addr_Out),
    .q_instr (Instruction_Out),
    .q_valid (Valid_Out)
  );

endmodule
